// File: rtl/vx_uop_collector_pkg.sv
// Shared types for the uop collector: per-warp collect state and the commit record
// that carries a parent instruction's merged results.
package vx_uop_collector_pkg;

  localparam int VX_NUM_WARPS = 4;
  localparam int UUID_WIDTH   = 16;
  localparam int PC_BITS      = 32;
  localparam int NUM_THREADS  = 4;

  typedef enum logic {
    UC_IDLE    = 1'b0,
    UC_COLLECT = 1'b1
  } uop_collect_state_e;

  // The uop count is kept beside the record because its width is a module parameter.
  typedef struct packed {
    logic [UUID_WIDTH-1:0]  uuid;
    logic [PC_BITS-1:0]     pc;
    logic [NUM_THREADS-1:0] tmask;
    logic                   wb;
  } uop_commit_rec_t;

endpackage

// File: rtl/vx_uop_collector_slot.sv
// One warp's collector: tracks the open parent and decides, per accepted beat,
// whether that beat completes a commit or breaks the sop/eop protocol.
module vx_uop_collector_slot
  import vx_uop_collector_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_fire,
  input  logic               i_sop,
  input  logic               i_eop,
  input  uop_commit_rec_t    i_beat,
  output logic               o_emit,
  output logic               o_err,
  output uop_commit_rec_t    o_rec,
  output logic [CNT_W-1:0]   o_cnt,
  output uop_collect_state_e o_state
);

  uop_collect_state_e r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
  uop_commit_rec_t    r_acc, w_acc_nxt;

  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
  assign o_state   = r_state;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    o_emit      = 1'b0;
    o_err       = 1'b0;
    o_rec       = '0;
    o_cnt       = '0;
    if (i_fire) begin
      if (i_sop) begin
        // A sop always opens a fresh parent; an unfinished one is thrown away.
        o_err = (r_state == UC_COLLECT);
        if (i_eop) begin
          o_emit      = 1'b1;
          o_rec       = i_beat;
          o_cnt       = CNT_W'(1);
          w_state_nxt = UC_IDLE;
          w_cnt_nxt   = '0;
          w_acc_nxt   = '0;
        end else begin
          w_state_nxt = UC_COLLECT;
          w_cnt_nxt   = CNT_W'(1);
          w_acc_nxt   = i_beat;
        end
      end else if (r_state == UC_IDLE) begin
        o_err = 1'b1;
      end else if (!i_eop) begin
        w_cnt_nxt       = w_cnt_inc;
        w_acc_nxt.tmask = r_acc.tmask | i_beat.tmask;
        w_acc_nxt.wb    = r_acc.wb | i_beat.wb;
      end else begin
        o_emit      = 1'b1;
        o_rec.uuid  = r_acc.uuid;
        o_rec.pc    = r_acc.pc;
        o_rec.tmask = r_acc.tmask | i_beat.tmask;
        o_rec.wb    = r_acc.wb | i_beat.wb;
        o_cnt       = w_cnt_inc;
        w_state_nxt = UC_IDLE;
        w_cnt_nxt   = '0;
        w_acc_nxt   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= UC_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

endmodule

// File: rtl/vx_uop_collector.sv
// Merges the per-uop results of expanded instructions into one commit per parent,
// with per-warp collect slots feeding a single shared output register.
module vx_uop_collector
  import vx_uop_collector_pkg::*;
#(
  parameter int NUM_WARPS = VX_NUM_WARPS,
  parameter int CNT_W     = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [$clog2(NUM_WARPS)-1:0] in_wid,
  input  logic [UUID_WIDTH-1:0]        in_uuid,
  input  logic [PC_BITS-1:0]           in_PC,
  input  logic [NUM_THREADS-1:0]       in_tmask,
  input  logic                         in_wb,
  input  logic                         in_sop,
  input  logic                         in_eop,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(NUM_WARPS)-1:0] out_wid,
  output logic [UUID_WIDTH-1:0]        out_uuid,
  output logic [PC_BITS-1:0]           out_PC,
  output logic [NUM_THREADS-1:0]       out_tmask,
  output logic                         out_wb,
  output logic [CNT_W-1:0]             out_uop_cnt,
  output logic                         err,
  output logic [NUM_WARPS-1:0]         dbg_collect
);

  localparam int NW_W = $clog2(NUM_WARPS);

  // Handshake: a transfer happens on a rising edge where valid && ready; once
  // out_valid is high the record is held unchanged until out_ready. The input side
  // is ready whenever the output register is empty or draining in the same cycle,
  // so the ready path never depends on in_valid.
  logic               w_in_fire, w_emit_sel, w_err_sel;
  logic               w_slot_fire [NUM_WARPS];
  logic               w_slot_emit [NUM_WARPS];
  logic               w_slot_err  [NUM_WARPS];
  uop_commit_rec_t    w_slot_rec  [NUM_WARPS];
  logic [CNT_W-1:0]   w_slot_cnt  [NUM_WARPS];
  uop_collect_state_e w_slot_st   [NUM_WARPS];
  uop_commit_rec_t    w_beat;

  logic               r_out_valid, r_err;
  logic [NW_W-1:0]    r_out_wid;
  uop_commit_rec_t    r_out_rec;
  logic [CNT_W-1:0]   r_out_cnt;

  assign in_ready  = ~r_out_valid | out_ready;
  assign w_in_fire = in_valid & in_ready;
  assign w_beat    = '{uuid: in_uuid, pc: in_PC, tmask: in_tmask, wb: in_wb};

  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_slot
    assign w_slot_fire[g] = w_in_fire && (in_wid == NW_W'(g));
    assign dbg_collect[g] = (w_slot_st[g] == UC_COLLECT);

    vx_uop_collector_slot #(.CNT_W(CNT_W)) u_slot (
      .clk     (clk),
      .reset_n (reset_n),
      .i_fire  (w_slot_fire[g]),
      .i_sop   (in_sop),
      .i_eop   (in_eop),
      .i_beat  (w_beat),
      .o_emit  (w_slot_emit[g]),
      .o_err   (w_slot_err[g]),
      .o_rec   (w_slot_rec[g]),
      .o_cnt   (w_slot_cnt[g]),
      .o_state (w_slot_st[g])
    );
  end

  assign w_emit_sel = w_slot_emit[in_wid];
  assign w_err_sel  = w_slot_err[in_wid];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
      r_out_wid   <= '0;
      r_out_rec   <= '0;
      r_out_cnt   <= '0;
    end else begin
      r_err <= w_in_fire & w_err_sel;
      if (w_in_fire && w_emit_sel) begin
        r_out_valid <= 1'b1;
        r_out_wid   <= in_wid;
        r_out_rec   <= w_slot_rec[in_wid];
        r_out_cnt   <= w_slot_cnt[in_wid];
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_wid     = r_out_wid;
  assign out_uuid    = r_out_rec.uuid;
  assign out_PC      = r_out_rec.pc;
  assign out_tmask   = r_out_rec.tmask;
  assign out_wb      = r_out_rec.wb;
  assign out_uop_cnt = r_out_cnt;
  assign err         = r_err;

endmodule

// File: tb/tb_vx_uop_collector.sv
// Directed bench for vx_uop_collector: passthrough, collection, interleave,
// backpressure, protocol errors, reset mid-collect and count saturation.
module tb_vx_uop_collector;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_wid = '0;
  logic [15:0] in_uuid = '0;
  logic [31:0] in_PC = '0;
  logic [3:0]  in_tmask = '0;
  logic        in_wb = 1'b0;
  logic        in_sop = 1'b0;
  logic        in_eop = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  out_wid;
  logic [15:0] out_uuid;
  logic [31:0] out_PC;
  logic [3:0]  out_tmask;
  logic        out_wb;
  logic [3:0]  out_uop_cnt;
  logic        err;
  logic [3:0]  dbg_collect;

  int n_cmp = 0;
  int n_bad = 0;

  vx_uop_collector #(.NUM_WARPS(4), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_wid(in_wid), .in_uuid(in_uuid),
    .in_PC(in_PC), .in_tmask(in_tmask), .in_wb(in_wb), .in_sop(in_sop), .in_eop(in_eop),
    .out_valid(out_valid), .out_ready(out_ready), .out_wid(out_wid), .out_uuid(out_uuid),
    .out_PC(out_PC), .out_tmask(out_tmask), .out_wb(out_wb), .out_uop_cnt(out_uop_cnt),
    .err(err), .dbg_collect(dbg_collect)
  );

  always #5 clk = ~clk;

  // Presents one beat for one rising edge and returns 1 time unit after that edge.
  task automatic beat(input logic [1:0] wid, input logic [15:0] uuid, input logic [31:0] pc,
                      input logic [3:0] tm, input logic wb, input logic sop, input logic eop);
    in_valid = 1'b1; in_wid = wid; in_uuid = uuid; in_PC = pc;
    in_tmask = tm; in_wb = wb; in_sop = sop; in_eop = eop;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%b exp=0", err); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready_during got=%b exp=1", in_ready); end
    n_cmp++; if ({out_uuid, out_PC, out_tmask, out_wb, out_uop_cnt, out_wid} !== '0) begin
      n_bad++; $display("FAIL rst_out_data got uuid=%h pc=%h tm=%b cnt=%0d exp all 0", out_uuid, out_PC, out_tmask, out_uop_cnt); end
    n_cmp++; if (dbg_collect !== 4'b0000) begin n_bad++; $display("FAIL rst_state got=%b exp=0000", dbg_collect); end
    @(negedge clk); reset_n = 1'b1;
    idle_cycle();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready_after got=%b exp=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid_after got=%b exp=0", out_valid); end
  endtask

  task automatic test_passthrough();
    beat(2'd0, 16'd7, 32'h100, 4'b1010, 1'b1, 1'b1, 1'b1);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL pt_valid got=%b exp=1", out_valid); end
    n_cmp++; if (out_uuid !== 16'd7) begin n_bad++; $display("FAIL pt_uuid got=%0d exp=7", out_uuid); end
    n_cmp++; if (out_tmask !== 4'b1010) begin n_bad++; $display("FAIL pt_tmask got=%b exp=1010", out_tmask); end
    n_cmp++; if (out_uop_cnt !== 4'd1) begin n_bad++; $display("FAIL pt_cnt got=%0d exp=1", out_uop_cnt); end
    n_cmp++; if (out_PC !== 32'h100 || out_wb !== 1'b1 || out_wid !== 2'd0) begin
      n_bad++; $display("FAIL pt_fields got pc=%h wb=%b wid=%0d exp pc=100 wb=1 wid=0", out_PC, out_wb, out_wid); end
    n_cmp++; if (dbg_collect[0] !== 1'b0) begin n_bad++; $display("FAIL pt_state got=%b exp=0", dbg_collect[0]); end
    idle_cycle();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL pt_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_collect();
    beat(2'd1, 16'd9, 32'h200, 4'b0001, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL col_sop_noout got=%b exp=0", out_valid); end
    n_cmp++; if (dbg_collect[1] !== 1'b1) begin n_bad++; $display("FAIL col_state got=%b exp=1", dbg_collect[1]); end
    beat(2'd1, 16'd99, 32'h204, 4'b0010, 1'b1, 1'b0, 1'b0);
    beat(2'd1, 16'd98, 32'h208, 4'b0100, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL col_mid_noout got=%b exp=0", out_valid); end
    beat(2'd1, 16'd97, 32'h20c, 4'b1000, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL col_valid got=%b exp=1", out_valid); end
    n_cmp++; if (out_uuid !== 16'd9 || out_PC !== 32'h200) begin
      n_bad++; $display("FAIL col_parent got uuid=%0d pc=%h exp uuid=9 pc=200", out_uuid, out_PC); end
    n_cmp++; if (out_tmask !== 4'b1111) begin n_bad++; $display("FAIL col_tmask got=%b exp=1111", out_tmask); end
    n_cmp++; if (out_uop_cnt !== 4'd4) begin n_bad++; $display("FAIL col_cnt got=%0d exp=4", out_uop_cnt); end
    n_cmp++; if (out_wb !== 1'b1 || out_wid !== 2'd1) begin
      n_bad++; $display("FAIL col_wb_wid got wb=%b wid=%0d exp wb=1 wid=1", out_wb, out_wid); end
    n_cmp++; if (dbg_collect[1] !== 1'b0) begin n_bad++; $display("FAIL col_back_idle got=%b exp=0", dbg_collect[1]); end
    idle_cycle();
  endtask

  task automatic test_interleave();
    beat(2'd0, 16'd20, 32'h300, 4'b0011, 1'b0, 1'b1, 1'b0);
    beat(2'd2, 16'd30, 32'h400, 4'b1100, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (dbg_collect !== 4'b0101) begin n_bad++; $display("FAIL il_states got=%b exp=0101", dbg_collect); end
    beat(2'd0, 16'd21, 32'h304, 4'b0100, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (out_valid !== 1'b1 || out_wid !== 2'd0 || out_uuid !== 16'd20 || out_tmask !== 4'b0111 || out_uop_cnt !== 4'd2) begin
      n_bad++; $display("FAIL il_first got v=%b wid=%0d uuid=%0d tm=%b cnt=%0d exp v=1 wid=0 uuid=20 tm=0111 cnt=2",
                        out_valid, out_wid, out_uuid, out_tmask, out_uop_cnt); end
    beat(2'd2, 16'd31, 32'h404, 4'b0001, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (out_valid !== 1'b1 || out_wid !== 2'd2 || out_uuid !== 16'd30 || out_tmask !== 4'b1101 || out_uop_cnt !== 4'd2 || out_wb !== 1'b1) begin
      n_bad++; $display("FAIL il_second got v=%b wid=%0d uuid=%0d tm=%b cnt=%0d wb=%b exp v=1 wid=2 uuid=30 tm=1101 cnt=2 wb=1",
                        out_valid, out_wid, out_uuid, out_tmask, out_uop_cnt, out_wb); end
    idle_cycle();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL il_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    beat(2'd0, 16'd40, 32'h500, 4'b0001, 1'b0, 1'b1, 1'b1);
    // A pending commit for w1 waits while the output register is stalled.
    in_valid = 1'b1; in_wid = 2'd1; in_uuid = 16'd41; in_PC = 32'h600;
    in_tmask = 4'b0110; in_wb = 1'b1; in_sop = 1'b1; in_eop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_uuid !== 16'd40 || out_tmask !== 4'b0001 || out_PC !== 32'h500) begin
        n_bad++; $display("FAIL bp_hold[%0d] got v=%b rdy=%b uuid=%0d tm=%b pc=%h exp v=1 rdy=0 uuid=40 tm=0001 pc=500",
                          i, out_valid, in_ready, out_uuid, out_tmask, out_PC); end
      idle_cycle();
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_uuid !== 16'd41 || out_wid !== 2'd1 || out_tmask !== 4'b0110 || out_uop_cnt !== 4'd1) begin
      n_bad++; $display("FAIL bp_reload got v=%b uuid=%0d wid=%0d tm=%b cnt=%0d exp v=1 uuid=41 wid=1 tm=0110 cnt=1",
                        out_valid, out_uuid, out_wid, out_tmask, out_uop_cnt); end
    idle_cycle();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_errors();
    beat(2'd3, 16'd70, 32'h700, 4'b1111, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_idle_mid got=%b exp=1", err); end
    n_cmp++; if (out_valid !== 1'b0 || dbg_collect[3] !== 1'b0) begin
      n_bad++; $display("FAIL err_idle_drop got v=%b st=%b exp v=0 st=0", out_valid, dbg_collect[3]); end
    idle_cycle();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_pulse_width got=%b exp=0", err); end
    beat(2'd1, 16'd50, 32'h800, 4'b0001, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_clean_sop got=%b exp=0", err); end
    beat(2'd1, 16'd51, 32'h900, 4'b0010, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (err !== 1'b1 || out_valid !== 1'b0 || dbg_collect[1] !== 1'b1) begin
      n_bad++; $display("FAIL err_resop got err=%b v=%b st=%b exp err=1 v=0 st=1", err, out_valid, dbg_collect[1]); end
    beat(2'd1, 16'd52, 32'h904, 4'b0100, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (err !== 1'b0 || out_valid !== 1'b1 || out_uuid !== 16'd51 || out_PC !== 32'h900 || out_tmask !== 4'b0110 || out_uop_cnt !== 4'd2) begin
      n_bad++; $display("FAIL err_new_parent got err=%b v=%b uuid=%0d pc=%h tm=%b cnt=%0d exp err=0 v=1 uuid=51 pc=900 tm=0110 cnt=2",
                        err, out_valid, out_uuid, out_PC, out_tmask, out_uop_cnt); end
    idle_cycle();
  endtask

  task automatic test_reset_mid_collect();
    beat(2'd0, 16'd60, 32'ha00, 4'b0001, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (dbg_collect[0] !== 1'b1) begin n_bad++; $display("FAIL rmc_collect got=%b exp=1", dbg_collect[0]); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (dbg_collect !== 4'b0000 || out_valid !== 1'b0 || err !== 1'b0) begin
      n_bad++; $display("FAIL rmc_async got st=%b v=%b err=%b exp st=0000 v=0 err=0", dbg_collect, out_valid, err); end
    @(negedge clk); reset_n = 1'b1;
    idle_cycle();
    n_cmp++; if (out_valid !== 1'b0 || err !== 1'b0) begin
      n_bad++; $display("FAIL rmc_quiet got v=%b err=%b exp v=0 err=0", out_valid, err); end
    // The discarded parent's eop now lands on an IDLE warp.
    beat(2'd0, 16'd61, 32'ha04, 4'b0010, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (err !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rmc_orphan_eop got err=%b v=%b exp err=1 v=0", err, out_valid); end
    idle_cycle();
  endtask

  task automatic test_saturation();
    beat(2'd2, 16'd80, 32'hb00, 4'b0001, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) beat(2'd2, 16'd0, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0 || err !== 1'b0) begin
      n_bad++; $display("FAIL sat_mid got v=%b err=%b exp v=0 err=0", out_valid, err); end
    beat(2'd2, 16'd0, 32'h0, 4'b1000, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (out_valid !== 1'b1 || out_uop_cnt !== 4'd15 || out_uuid !== 16'd80 || out_tmask !== 4'b1001) begin
      n_bad++; $display("FAIL sat_commit got v=%b cnt=%0d uuid=%0d tm=%b exp v=1 cnt=15 uuid=80 tm=1001",
                        out_valid, out_uop_cnt, out_uuid, out_tmask); end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_collect();
    test_interleave();
    test_backpressure();
    test_errors();
    test_reset_mid_collect();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
